key_event_fifo: RTL and testbench
=================================

# key_event_fifo

Buffers key events from the 4x4 matrix scanner for the host CPU. Consumes the scanner's active-low key-qualified line and its 4-bit key code, and turns each debounced press into a FIFO entry. Presents entries on a simple pop-strobe read port with an active-low interrupt. Sits between the keyboard scanner and the CPU bus glue in the CPLD.

## Interface
- DEPTH, 8: FIFO entries; power of two, ≥2.
- AW, 3: log2(DEPTH).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- key_int_n  in  1  scanner key-qualified line; 0 while a key is held past debounce.
- key_data  in  4  scanner key code 0..15; updated by the scanner one cycle after key_int_n falls.
- rd_en  in  1  pop strobe, one cycle per entry.
- rd_data  out  5  popped event: [4] release flag, [3:0] key code; reset 0.
- rd_valid  out  1  rd_data valid this cycle; reset 0.
- empty  out  1  count==0; reset 1.
- full  out  1  count==DEPTH; reset 0.
- count  out  AW+1  entries held; reset 0.
- irq_n  out  1  active-low interrupt, 0 while count!=0; reset 1.
- ovf  out  1  sticky overflow flag; reset 0.
- ovf_clr  in  1  clears ovf.

## Operation
- Edge detect: key_int_n registered into int_d (reset 1). `armed` resets to 0 and sets on the first clock after reset. No edge is detected while `armed`=0. This prevents spurious events when a key is held across reset.
- Press: key_int_n=0, int_d=1, armed=1. This sets `pend` (press), and the push uses the following cycle's key_data. The one-cycle delay is mandatory because the scanner updates its code one cycle after key_int_n falls.
- Push writes {1'b0, key_data} at wr_ptr. wr_ptr wraps modulo DEPTH, and count increments.
- Pop: rd_en=1 with count!=0 registers mem[rd_ptr] into rd_data. rd_valid=1 for exactly that next cycle. rd_ptr wraps and count decrements. With count==0, rd_en is ignored: rd_valid=0 and rd_data is held.
- Push and pop in the same cycle: both execute and count is unchanged. This includes the full case, where the pop frees a slot and the push is accepted.
- Push with full and no pop: the entry is dropped, pointers and count are unchanged, and ovf is set.
- ovf_clr and a new overflow in the same cycle: the set wins.
- Pending push lost to reset: reset clears pend, pointers, count and flags. Storage contents are don't-care.
- A new edge while `pend` is set cannot occur, because debounce is far longer than 2 cycles. The RTL does not need to handle it.

## Timing
- key_int_n first sampled 0 at edge n, with int_d=1 → pend=1 after n. At edge n+1, key_data is written. count, empty, full and irq_n update after n+1.
- Press-to-irq_n latency: 2 clocks.
- rd_en high at edge m → rd_data and rd_valid valid after m, for one cycle. count updates after m.
- irq_n, empty and full are decoded directly from the count register, with no added delay.

## Configuration
- KEY_RELEASE_EVT_EN defined:
  - A rising edge of key_int_n (key_int_n=1, int_d=0, armed=1) also raises pend.
  - It pushes {1'b1, key_data} one cycle later, using the held last code.
  - Overflow rules are identical to press events.
- Undefined: rising edges are ignored, and rd_data[4] is always 0.

## Structure
- Package key_pkg: KEY_CODE_W=4, KEY_EVT_W=5, KEY_REL_BIT=4, and the event struct or typedef.
- Sub-module key_edge_detect: owns int_d and armed, and outputs the registered press_pend and release_pend pulses.
- FIFO pointers, count, storage and read port stay in key_event_fifo.

## Test plan
- Reset with key_int_n=0 held, then release reset → no push. count=0, irq_n=1.
- key_int_n falls, key_data=4'hA one cycle later → count=1 and irq_n=0 two clocks after the fall. rd_en pulse → rd_data=5'h0A, rd_valid for 1 cycle, count=0, irq_n=1.
- 9 presses (codes 0..8) with DEPTH=8 and no reads → count=8, full=1, ovf=1. Pops return 0..7 in order. ovf_clr → ovf=0.
- With count=8, the press push lands in the same cycle as rd_en → count stays 8, ovf=0, and the new code is the last entry read.
- rd_en with empty=1 → rd_valid=0, rd_data unchanged, count stays 0.
- KEY_RELEASE_EVT_EN: press code 5, then release → two entries 5'h05, 5'h15. Without the macro, only 5'h05.

Source files
------------

// File: rtl/key_pkg.sv
// Shared widths and event format for the keypad event FIFO.
// Event word is {release flag, key code}; release events exist only with KEY_RELEASE_EVT_EN.
package key_pkg;

  localparam int KEY_CODE_W  = 4;
  localparam int KEY_EVT_W   = 5;
  localparam int KEY_REL_BIT = 4;

  typedef struct packed {
    logic                  rel;
    logic [KEY_CODE_W-1:0] code;
  } key_evt_t;

  function automatic key_evt_t make_evt(input logic rel, input logic [KEY_CODE_W-1:0] code);
    key_evt_t e;
    e.rel  = rel;
    e.code = code;
    return e;
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Turns the scanner's key-qualified line into one-cycle press/release pulses, one clock after the edge.
// Edges are ignored for the first clock after reset; release pulses only with KEY_RELEASE_EVT_EN.
module key_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic key_int_n,
  output logic press_pend,
  output logic release_pend
);

  logic int_d;
  logic armed;

  // armed masks the first sample so a key held through reset never looks like a fresh press
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int_d        <= 1'b1;
      armed        <= 1'b0;
      press_pend   <= 1'b0;
      release_pend <= 1'b0;
    end else begin
      int_d        <= key_int_n;
      armed        <= 1'b1;
      press_pend   <= armed & int_d & ~key_int_n;
`ifdef KEY_RELEASE_EVT_EN
      release_pend <= armed & ~int_d & key_int_n;
`else
      release_pend <= 1'b0;
`endif
    end
  end

endmodule

// File: rtl/key_event_fifo.sv
// Key event FIFO: press-to-irq_n 2 clocks, pop data 1 clock after rd_en; push into a full FIFO is dropped and sets sticky ovf.
// KEY_RELEASE_EVT_EN adds release events ({1'b1, last code}); otherwise rd_data[4] is always 0.
module key_event_fifo
  import key_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_int_n,
  input  logic [KEY_CODE_W-1:0] key_data,
  input  logic                  rd_en,
  output logic [KEY_EVT_W-1:0]  rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  full,
  output logic [AW:0]           count,
  output logic                  irq_n,
  output logic                  ovf,
  input  logic                  ovf_clr
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic          press_pend;
  logic          release_pend;
  logic          push_req;
  logic          push_ok;
  logic          pop;
  logic          ovf_set;
  logic          is_full;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_q;
  key_evt_t      rd_data_q;
  key_evt_t      wr_evt;
  key_evt_t      mem [DEPTH];

  key_edge_detect u_edge (
    .clk          (clk),
    .rst          (rst),
    .key_int_n    (key_int_n),
    .press_pend   (press_pend),
    .release_pend (release_pend)
  );

  // The push lands one clock after the edge, when the scanner's code is valid.
  assign push_req = press_pend | release_pend;
  assign wr_evt   = make_evt(release_pend, key_data);
  assign is_full  = (count_q == FULL_CNT);
  assign pop      = rd_en & (count_q != '0);
  assign push_ok  = push_req & (~is_full | pop);
  assign ovf_set  = push_req & is_full & ~pop;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_evt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
      rd_valid  <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      rd_valid <= pop;
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_data_q <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      // a fresh overflow beats a simultaneous clear
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  assign rd_data = rd_data_q;
  assign count   = count_q;
  assign empty   = (count_q == '0);
  assign full    = is_full;
  assign irq_n   = (count_q == '0);

endmodule

// File: tb/tb_key_event_fifo.sv
// Bench for key_event_fifo: queue-based event model checked every cycle plus directed literal checks.
module tb_key_event_fifo;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
`ifdef KEY_RELEASE_EVT_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif
  localparam int NFILL = REL ? 4 : 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          key_int_n = 1'b0;
  logic [3:0]    key_data = 4'h0;
  logic          rd_en = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [4:0]    rd_data;
  logic          rd_valid;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          irq_n;
  logic          ovf;

  int checks = 0;
  int failures = 0;

  key_event_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .key_int_n (key_int_n),
    .key_data  (key_data),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .irq_n     (irq_n),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Event model: a queue of pending events, a sticky overflow flag and the last popped word.
  int q[$];
  int m_rd = 0;
  bit m_rv = 1'b0;
  bit m_ovf = 1'b0;
  bit m_prev = 1'b1;
  bit m_armed = 1'b0;
  bit m_pend = 1'b0;
  bit m_rel = 1'b0;
  bit m_pop;
  bit m_drop;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_rd = 0; m_rv = 1'b0; m_ovf = 1'b0;
      m_prev = 1'b1; m_armed = 1'b0; m_pend = 1'b0; m_rel = 1'b0;
    end else begin
      m_pop  = rd_en && (q.size() > 0);
      m_drop = 1'b0;
      m_rv   = m_pop;
      if (m_pop) m_rd = q.pop_front();
      if (m_pend) begin
        if (q.size() < DEPTH) q.push_back((m_rel ? 16 : 0) + int'(key_data));
        else m_drop = 1'b1;
      end
      m_ovf   = m_drop ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
      m_rel   = REL && m_armed && !m_prev && key_int_n;
      m_pend  = (m_armed && m_prev && !key_int_n) || m_rel;
      m_prev  = key_int_n;
      m_armed = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("cyc_count", int'(count), q.size());
      chk("cyc_empty", int'(empty), (q.size() == 0) ? 1 : 0);
      chk("cyc_full", int'(full), (q.size() == DEPTH) ? 1 : 0);
      chk("cyc_irq_n", int'(irq_n), (q.size() == 0) ? 1 : 0);
      chk("cyc_ovf", int'(ovf), int'(m_ovf));
      chk("cyc_rd_valid", int'(rd_valid), int'(m_rv));
      chk("cyc_rd_data", int'(rd_data), m_rd);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] code, input bit rd, input bit clr);
    key_int_n = 1'b0;
    tick(1);
    key_data = code;
    rd_en    = rd;
    ovf_clr  = clr;
    tick(1);
    rd_en    = 1'b0;
    ovf_clr  = 1'b0;
  endtask

  task automatic release_key();
    key_int_n = 1'b1;
    tick(3);
  endtask

  task automatic pop1();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() > 0 && guard < 40) begin
      rd_en = 1'b1;
      tick(1);
      guard++;
    end
    rd_en = 1'b0;
    chk("drain_bound", (guard < 40) ? 1 : 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with the key held
    rst = 1'b0; key_int_n = 1'b0;
    tick(3);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_irq_n", int'(irq_n), 1);
    chk("rst_ovf", int'(ovf), 0);
    rst = 1'b1;
    tick(4);
    chk("held_count", int'(count), 0);
    chk("held_irq_n", int'(irq_n), 1);
    rst = 1'b0; tick(1); key_int_n = 1'b1; tick(1); rst = 1'b1;
    tick(3);

    // single press of 0xA
    key_int_n = 1'b0;
    tick(1);
    chk("pend_irq_n", int'(irq_n), 1);
    key_data = 4'hA;
    tick(1);
    chk("press_count", int'(count), 1);
    chk("press_irq_n", int'(irq_n), 0);
    release_key();
    chk("queued", int'(count), REL ? 2 : 1);
    pop1();
    chk("pop_valid", int'(rd_valid), 1);
    chk("pop_data", int'(rd_data), 'h0A);
    tick(1);
    chk("pop_valid_once", int'(rd_valid), 0);
    drain();
    chk("a_last", int'(rd_data), REL ? 'h1A : 'h0A);
    chk("a_count", int'(count), 0);
    chk("a_irq_n", int'(irq_n), 1);

    // overflow: 9 presses, last one with ovf_clr on the dropping edge
    for (int i = 0; i < 9; i++) begin
      press(4'(i), 1'b0, i == 8);
      release_key();
    end
    chk("ovf_count", int'(count), 8);
    chk("ovf_full", int'(full), 1);
    chk("ovf_set", int'(ovf), 1);
    for (int i = 0; i < 8; i++) begin
      pop1();
      chk("ovf_pop", int'(rd_data), REL ? (((i & 1) << 4) | (i >> 1)) : i);
    end
    chk("ovf_sticky", int'(ovf), 1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("ovf_cleared", int'(ovf), 0);

    // push and pop on the same edge while full
    for (int i = 0; i < NFILL; i++) begin
      press(4'(i), 1'b0, 1'b0);
      release_key();
    end
    chk("fill_full", int'(full), 1);
    press(4'h9, 1'b1, 1'b0);
    chk("simul_count", int'(count), 8);
    chk("simul_ovf", int'(ovf), 0);
    chk("simul_valid", int'(rd_valid), 1);
    pop1();
    release_key();
    chk("simul_ovf2", int'(ovf), 0);
    drain();
    chk("simul_last", int'(rd_data), REL ? 'h19 : 'h09);

    // pop while empty
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    chk("empty_valid", int'(rd_valid), 0);
    chk("empty_data", int'(rd_data), REL ? 'h19 : 'h09);
    chk("empty_count", int'(count), 0);

    // press then release of code 5
    press(4'h5, 1'b0, 1'b0);
    release_key();
    chk("rel_count", int'(count), REL ? 2 : 1);
    pop1();
    chk("rel_first", int'(rd_data), 'h05);
    drain();
    chk("rel_last", int'(rd_data), REL ? 'h15 : 'h05);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
